// File: rtl/timer16.sv
// 16-bit programmable down-counting timer with prescaler, periodic/one-shot modes,
// a one-cycle terminal-count interrupt and a sampled count readback register.
module timer16 #(
  parameter int unsigned PRESCALE    = 1,
  parameter bit          AUTO_RELOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_cs,
  input  logic        timer_wr,
  input  logic        timer_start,
  input  logic        timer_rd,
  input  logic [15:0] timer_datain,
  output logic [15:0] timer_value,
  output logic        timer_INT
);

  localparam logic [15:0] PsLast = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_reload, r_count, r_pscnt, r_value;
  logic [15:0] w_count_d, w_pscnt_d, w_reload_next;
  logic        r_int, w_int_d;
  logic        w_run_en, w_wr_en, w_rd_en, w_tick;

  assign w_run_en      = timer_cs & timer_start;
  assign w_wr_en       = timer_cs & timer_wr;
  assign w_rd_en       = timer_cs & timer_rd;
  // A write on the same edge as a reload wins over the stored value.
  assign w_reload_next = w_wr_en ? timer_datain : r_reload;
  assign w_tick        = (r_state == StRun) && (r_pscnt == PsLast);

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_pscnt_d = r_pscnt;
    w_int_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_pscnt_d = '0;
        if (w_run_en) w_state_d = StLoad;
      end
      StLoad: begin
        w_count_d = w_reload_next;
        w_pscnt_d = '0;
        w_state_d = StRun;
      end
      StRun: begin
        // Stop takes priority over a coincident terminal tick: no pulse, count holds.
        if (!w_run_en) begin
          w_pscnt_d = '0;
          w_state_d = StIdle;
        end else if (w_tick) begin
          w_pscnt_d = '0;
          if (r_count != 16'd1) begin
            w_count_d = r_count - 16'd1;
          end else begin
            w_int_d = 1'b1;
            if (AUTO_RELOAD) begin
              w_count_d = w_reload_next;
            end else begin
              w_count_d = '0;
              w_state_d = StDone;
            end
          end
        end else begin
          w_pscnt_d = r_pscnt + 16'd1;
        end
      end
      StDone: begin
        w_pscnt_d = '0;
        w_count_d = '0;
        if (!w_run_en) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_reload <= '0;
      r_count  <= '0;
      r_pscnt  <= '0;
      r_value  <= '0;
      r_int    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_pscnt <= w_pscnt_d;
      r_int   <= w_int_d;
      if (w_wr_en) r_reload <= timer_datain;
      if (w_rd_en) r_value <= r_count;
    end
  end

  assign timer_value = r_value;
  assign timer_INT   = r_int;

endmodule

// File: tb/tb_timer16.sv
// Bench for timer16: three parameterisations share one stimulus stream and are checked
// against a tick-arithmetic reference model, a directed table and hand-built corner cases.
module tb_timer16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, start = 1'b0, rd = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] val_p1, val_os, val_p3;
  logic        int_p1, int_os, int_p3;

  always #5 clk = ~clk;

  timer16 #(.PRESCALE(1), .AUTO_RELOAD(1'b1)) u_p1 (
    .clk(clk), .rst(rst), .timer_cs(cs), .timer_wr(wr), .timer_start(start),
    .timer_rd(rd), .timer_datain(din), .timer_value(val_p1), .timer_INT(int_p1)
  );
  timer16 #(.PRESCALE(4), .AUTO_RELOAD(1'b0)) u_os (
    .clk(clk), .rst(rst), .timer_cs(cs), .timer_wr(wr), .timer_start(start),
    .timer_rd(rd), .timer_datain(din), .timer_value(val_os), .timer_INT(int_os)
  );
  timer16 #(.PRESCALE(3), .AUTO_RELOAD(1'b1)) u_p3 (
    .clk(clk), .rst(rst), .timer_cs(cs), .timer_wr(wr), .timer_start(start),
    .timer_rd(rd), .timer_datain(din), .timer_value(val_p3), .timer_INT(int_p3)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per instance, tracks elapsed cycles within the current period and
  // derives the count as period - elapsed/P.
  localparam int MIdle = 0, MLoad = 1, MRun = 2, MDone = 3;
  int          m_p  [3] = '{1, 4, 3};
  bit          m_ar [3] = '{1'b1, 1'b0, 1'b1};
  int          m_mode [3];
  int          m_t    [3];
  int          m_per  [3];
  logic [15:0] m_reload [3];
  logic [15:0] m_count  [3];
  logic [15:0] m_val    [3];
  logic        m_int    [3];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = MIdle; m_t[i] = 0; m_per[i] = 0;
      m_reload[i] = '0; m_count[i] = '0; m_val[i] = '0; m_int[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic        rn, wn, rdn, pulse;
    logic [15:0] rnext, vnew;
    if (!rst) begin
      model_reset();
      return;
    end
    rn  = cs & start;
    wn  = cs & wr;
    rdn = cs & rd;
    for (int i = 0; i < 3; i++) begin
      rnext = wn ? din : m_reload[i];
      vnew  = rdn ? m_count[i] : m_val[i];
      pulse = 1'b0;
      case (m_mode[i])
        MIdle: if (rn) m_mode[i] = MLoad;
        MLoad: begin
          m_per[i]   = (rnext == 16'd0) ? 65536 : int'(rnext);
          m_t[i]     = 0;
          m_count[i] = rnext;
          m_mode[i]  = MRun;
        end
        MRun: begin
          if (!rn) begin
            m_mode[i] = MIdle;
          end else begin
            m_t[i]++;
            if (m_t[i] == m_per[i] * m_p[i]) begin
              pulse = 1'b1;
              if (m_ar[i]) begin
                m_per[i]   = (rnext == 16'd0) ? 65536 : int'(rnext);
                m_t[i]     = 0;
                m_count[i] = rnext;
              end else begin
                m_count[i] = '0;
                m_mode[i]  = MDone;
              end
            end else begin
              m_count[i] = 16'(m_per[i] - m_t[i] / m_p[i]);
            end
          end
        end
        default: if (!rn) m_mode[i] = MIdle;
      endcase
      m_reload[i] = rnext;
      m_val[i]    = vnew;
      m_int[i]    = pulse;
    end
  endtask

  task automatic compare_all();
    chk16("val_p1", val_p1, m_val[0]);
    chk_bit("int_p1", int_p1, m_int[0]);
    chk16("val_os", val_os, m_val[1]);
    chk_bit("int_os", int_os, m_int[1]);
    chk16("val_p3", val_p3, m_val[2]);
    chk_bit("int_p3", int_p3, m_int[2]);
  endtask

  // Inputs are only changed 1 time unit after an edge, so the model sees what the DUT sampled.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_all(input int n);
    start = 1'b0; wr = 1'b0; rd = 1'b0; cs = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_cycle_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk16("arst_val_p1", val_p1, 16'h0000);
    chk_bit("arst_int_p1", int_p1, 1'b0);
    compare_all();
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic        cs, wr, start, rd;
    logic [15:0] din;
    logic        exp_int;
    logic [15:0] exp_val;
  } vec_t;

  vec_t tbl [19];
  int   first;

  initial begin
    // Periodic P=1, R=5: pulses at edges k+6, k+11, k+16 (row j is edge k+j-1).
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0, 16'h0000};
    for (int j = 1; j < 19; j++)
      tbl[j] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, (j == 7 || j == 12 || j == 17), 16'h0000};

    model_reset();

    // Reset held with random controls.
    for (int i = 0; i < 3; i++) begin
      cs = 1'($urandom); wr = 1'($urandom); start = 1'($urandom); rd = 1'($urandom);
      din = 16'($urandom);
      step();
      chk16("rst_val", val_p1, 16'h0000);
      chk_bit("rst_int", int_p1, 1'b0);
    end
    cs = 1'b0; wr = 1'b0; start = 1'b0; rd = 1'b0; din = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk16("post_rst_val", val_os, 16'h0000);
      chk_bit("post_rst_int", int_os, 1'b0);
    end

    for (int j = 0; j < 19; j++) begin
      cs = tbl[j].cs; wr = tbl[j].wr; start = tbl[j].start; rd = tbl[j].rd; din = tbl[j].din;
      step();
      chk_bit("tbl_int", int_p1, tbl[j].exp_int);
      chk16("tbl_val", val_p1, tbl[j].exp_val);
    end

    // One-shot P=4, R=3: single pulse at k+13, then count 0; restart gives a new pulse.
    idle_all(3);
    wr = 1'b1; din = 16'd3; step();
    wr = 1'b0; start = 1'b1; step();
    for (int j = 1; j <= 30; j++) begin
      step();
      chk_bit("os_int", int_os, j == 13);
    end
    rd = 1'b1; step();
    chk16("os_count0", val_os, 16'h0000);
    rd = 1'b0; start = 1'b0; step(); step();
    start = 1'b1; step();
    for (int j = 1; j <= 20; j++) begin
      step();
      chk_bit("os_restart_int", int_os, j == 13);
    end

    // Readback: R=0x100, rd sampled only at edge k+11.
    idle_all(2);
    wr = 1'b1; din = 16'h0100; step();
    wr = 1'b0; start = 1'b1; step();
    for (int j = 1; j <= 14; j++) begin
      rd = (j == 11);
      step();
      if (j >= 12) chk16("rb_val", val_p1, 16'h00F7);
    end
    rd = 1'b0;

    // Rewrite to 3 at edge k+5 while running R=10.
    idle_all(2);
    wr = 1'b1; din = 16'd10; step();
    wr = 1'b0; start = 1'b1; step();
    for (int j = 1; j <= 16; j++) begin
      wr = (j == 5); din = 16'd3;
      step();
      chk_bit("wmid_int", int_p1, j == 11 || j == 14);
    end
    wr = 1'b0;

    // cs dropped on the terminal-tick edge; restart proves the FSM went back to IDLE.
    idle_all(2);
    wr = 1'b1; din = 16'd5; step();
    wr = 1'b0; start = 1'b1; step();
    for (int j = 1; j <= 20; j++) begin
      cs = !(j >= 6 && j <= 9);
      step();
      chk_bit("csdrop_int", int_p1, j == 16);
    end
    cs = 1'b1;

    // R=1, P=1: continuous interrupt, then async reset kills it mid-cycle.
    idle_all(2);
    wr = 1'b1; din = 16'd1; step();
    wr = 1'b0; start = 1'b1; step();
    for (int j = 1; j <= 6; j++) begin
      step();
      chk_bit("r1_int", int_p1, j >= 2);
    end
    mid_cycle_reset();

    // R=0: 65536-tick period.
    cs = 1'b1; start = 1'b0; wr = 1'b1; din = 16'd0; step();
    wr = 1'b0; start = 1'b1; step();
    first = -1;
    for (int j = 1; j <= 65540; j++) begin
      step();
      if (int_p1 && first < 0) first = j;
    end
    chk32("r0_first_pulse", first, 65537);

    // Randomised traffic, occasional asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      cs    = ($urandom % 8) != 0;
      wr    = ($urandom % 6) == 0;
      start = ($urandom % 12) != 0;
      rd    = 1'($urandom);
      din   = 16'($urandom_range(11, 0));
      step();
      if ($urandom % 300 == 0) mid_cycle_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer16.md
# timer16

16-bit programmable down-counting timer peripheral that sits directly downstream of the MCU controller's timer control outputs and feeds its `timer_INT` and `timer_value` inputs back. The controller programs a reload value through `timer_datain` and drives four static control levels from its TC register (cs, wr, start, rd). The timer counts prescaled clock ticks and emits a one-cycle interrupt pulse at terminal count. It also exposes a sampled count value for readback.

## Interface
Parameters:
- `PRESCALE`, default 1: clock cycles per count tick. Legal range is 1..65535.
- `AUTO_RELOAD`, default 1: 1 selects periodic mode, 0 selects one-shot mode.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `timer_cs`, input, 1: chip select. All other controls are ignored while this is low.
- `timer_wr`, input, 1: level. While `cs&wr` is high, the reload register is written from `timer_datain` every cycle.
- `timer_start`, input, 1: level. `run_en = cs&start`.
- `timer_rd`, input, 1: level. While `cs&rd` is high, `timer_value` tracks the count.
- `timer_datain`, input, 16: reload value.
- `timer_value`, output, 16: registered count snapshot.
- `timer_INT`, output, 1: registered single-cycle terminal-count pulse.

## Operation
Internal registers:
- `reload[15:0]`
- `count[15:0]`
- `pscnt[15:0]`
- `state` with values IDLE, LOAD, RUN, DONE

Tick generation:
- `tick` is asserted when state is RUN and `pscnt == PRESCALE-1`.
- On `tick`, `pscnt` is cleared. Otherwise, in RUN, `pscnt` increments.

Reload register:
- `reload <= timer_datain` on any edge where `cs&wr` is sampled high, in any state.

State machine:
- IDLE: `count` holds and `pscnt` is 0. Go to LOAD when `run_en` is sampled high.
- LOAD: `count <= reload_next` and `pscnt <= 0`. Go to RUN. `reload_next` is `timer_datain` if a write occurs on the same edge, otherwise `reload`.
- RUN, when `run_en` is low: go to IDLE. `count` holds and no pulse is generated. Restarting always passes through LOAD; there is no pause/resume.
- RUN, when `tick` is high and `count != 1`: `count <= count-1`.
- RUN, when `tick` is high and `count == 1`:
  - `timer_INT <= 1` for exactly one cycle.
  - If `AUTO_RELOAD`: `count <= reload_next` and stay in RUN.
  - Otherwise: `count <= 0` and go to DONE.
- DONE: `count` holds 0 and no further pulses are generated. Go to IDLE when `run_en` is sampled low.

Readback and interrupt outputs:
- `timer_value <= count` on every edge where `cs&rd` is high. Otherwise it holds its last value.
- `timer_INT` is 0 on every edge that is not a terminal tick.

Arithmetic:
- All arithmetic is unsigned 16-bit with wrap.
- A reload of 0 loads 0. The first tick wraps `count` to 0xFFFF, giving a 65536-tick period.

Boundary conditions:
- A write during RUN does not disturb `count`. It takes effect at the next reload.
- A write on the same edge as a terminal tick or LOAD uses the new value.
- If `run_en` drops on the same edge as a terminal tick, RUN takes the `run_en`-low branch to IDLE. No pulse is generated and `count` holds.

Reset (`rst` low), asynchronous:
- State goes to IDLE.
- `count`, `reload`, `pscnt`, `timer_value` and `timer_INT` all go to 0.
- Asserting reset mid-RUN cancels any pending pulse immediately.

## Timing
- Let edge k be the first edge sampling `run_en` high from IDLE. LOAD occurs at edge k+1, and `count` equals R after edge k+1.
- The first terminal tick is at edge k+1+R·P, where P = `PRESCALE`. `timer_INT` is high in the cycle following that edge.
- In periodic mode, subsequent pulses are spaced exactly R·P cycles apart (65536·P when R = 0).
- `timer_INT` is never high on two consecutive cycles when P·R ≥ 2. With P = 1 and R = 1, it is high continuously while running.
- `timer_value` lags `count` by one edge while `cs&rd` is high.
- Control inputs are assumed synchronous to `clk`. They come from the controller's TC register.

## Test plan
- Reset: hold `rst` low with random inputs -> `timer_value` = 0 and `timer_INT` = 0. Release with no controls -> outputs stay 0 and state stays IDLE.
- Periodic, P = 1: write 0x0005, then set `start` with `cs` high -> `timer_INT` pulses at edges k+6, k+11 and k+16, each pulse exactly one cycle wide.
- One-shot (`AUTO_RELOAD` = 0), P = 4, R = 3 -> a single pulse at edge k+13, then `count` = 0 and no further pulse. Drop `start`, then raise it again -> a new pulse 13 edges after the new start edge.
- Readback: R = 0x0100 running, P = 1, `rd` high from edge k+11 -> `timer_value` = 0x00F7 after edge k+12. Drop `rd` -> `timer_value` frozen.
- Write mid-run: R = 10, rewrite 0x0003 at edge k+5 -> first pulse still at k+11, next pulse at k+14.
- Stop/edge cases:
  - Drop `cs` at the edge of a terminal tick -> no pulse, state goes to IDLE.
  - R = 0 -> first pulse at edge k+65537.
  - Assert `rst` mid-run -> all outputs become 0 asynchronously.
